fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage; the producing end of the branch-target datapath.
- Generates the PC, PC+4 and 16-bit immediate consumed by the branch-target adder chain (PC+4 adder, sign-extend, shift-left-2, target adder).
- Accepts the resolved branch target back as a redirect.
- Talks to instruction memory over a req/gnt + rvalid interface and presents one fetched instruction to decode over a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request
- imem_addr  output  32  word-aligned fetch address; valid while imem_req=1
- imem_gnt  input  1  request accepted this cycle
- imem_rvalid  input  1  read data valid; at least 1 cycle after gnt; one response per grant
- imem_rdata  input  32  instruction word
- if_valid  output  1  output register holds an instruction
- if_ready  input  1  decode accepts the instruction this cycle
- if_pc  output  32  PC of the held instruction
- if_pc4  output  32  if_pc + 4, mod 2^32
- if_instr  output  32  held instruction
- if_imm16  output  16  if_instr[15:0]
- br_taken  input  1  single-cycle redirect pulse
- br_target  input  32  redirect address, sampled when br_taken=1
- br_misaligned  output  1  one-cycle pulse: br_target[1:0] was nonzero on redirect

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=REQ, drop=0.
  - if_valid=0, imem_req=0, br_misaligned=0.
  - if_pc, if_pc4, if_instr = 0.
  - Reset overrides every other input, including mid-transaction; responses arriving after reset for a pre-reset grant must be covered by the memory being reset together with this block.
- States:
  - REQ:
    - imem_req = (!if_valid || if_ready) && !br_taken.
    - imem_addr = pc.
    - On req && gnt: save req_pc = pc, go to WAIT.
  - WAIT:
    - imem_req = 0.
    - On rvalid with drop=1: discard data, clear drop, go to REQ.
    - On rvalid with drop=0: load the output register (if_instr = rdata, if_pc = req_pc, if_pc4 = req_pc+4, if_valid = 1), set pc = req_pc+4, go to REQ.
- Output register is a single entry:
  - Cleared (if_valid=0) when if_valid && if_ready and no load occurs in the same cycle.
  - Load and consume in the same cycle is legal; the new entry wins.
- Redirect (br_taken=1) has priority over every non-reset event:
  - pc = {br_target[31:2], 2'b00}.
  - br_misaligned = |br_target[1:0] next cycle.
  - if_valid = 0; any rvalid load that cycle is suppressed.
  - In WAIT without rvalid this cycle: drop=1, stay in WAIT.
  - In WAIT with rvalid this cycle: data discarded, go to REQ.
  - In REQ: imem_req is forced 0, so no stale grant is possible; stay in REQ.
  - A second br_taken while drop=1: pc updates; drop stays 1 (still one outstanding response).
- Latency:
  - REQ→gnt→rvalid→if_valid, with if_valid rising the cycle after rvalid.
  - Peak throughput is 1 instruction per 2 cycles with 1-cycle memory.
- Wrap-around: pc+4 at 32'hFFFF_FFFC yields 32'h0000_0000. No error flag.
- Stability: while if_valid=1 and if_ready=0, all if_* outputs hold stable.
- imem_addr[1:0] is always 2'b00.

Decomposition:
- Shared package:
  - state enum {REQ, WAIT}
  - constant WORD_BYTES=4
  - constant RESET_PC default
  - instruction field slice constants (IMM_LSB=0, IMM_MSB=15)
- One natural sub-module: fetch_out_reg, the single-entry valid/ready holding register with load/flush/consume.
- The FSM, pc and drop logic stay in fetch_unit.

Test Plan:
- Reset, then gnt=1 immediately and rvalid 1 cycle later with rdata=32'h1000_0003, if_ready=1 → imem_addr sequence 0x0, 0x4, 0x8; first output if_pc=0x0, if_pc4=0x4, if_imm16=16'h0003.
- Backpressure: if_ready=0 for 5 cycles with if_valid=1 → imem_req=0, if_* stable; raise if_ready → next request at if_pc+4.
- Redirect during WAIT: br_taken=1, br_target=0x40 one cycle after gnt for 0x8; rvalid arrives 2 cycles later with 0xDEAD_BEEF → data discarded, next imem_addr=0x40, if_valid never shows 0xDEAD_BEEF.
- Redirect coincident with rvalid → rvalid data discarded, next request at target, drop=0.
- Misaligned target 0x0000_0102 → imem_addr=0x100, br_misaligned pulses for exactly 1 cycle.
- RESET_PC=32'hFFFF_FFFC → first if_pc4=0x0, second fetch address 0x0.
- rst asserted while in WAIT → next cycle if_valid=0, imem_req=0, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_unit_pkg;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned IMM_LSB          = 0;
    localparam int unsigned IMM_MSB          = 15;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// rtl/fetch_out_reg.sv - single-entry valid/ready holding register for fetched instructions
module fetch_out_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic        ready_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] instr_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] instr_q, instr_d;

    // Flush beats load beats consume; a load in the consume cycle replaces the entry.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            pc4_d   = pc_i + 32'(WORD_BYTES);
            instr_d = instr_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            pc4_q   <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: pc, imem req/gnt/rvalid, redirect, decode handshake
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_instr,
    output logic [15:0] if_imm16,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        br_misaligned
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        drop_q, drop_d;
    logic        br_mis_q;
    logic        rsp_fire;
    logic        load;

    // Request is also held low during reset so no grant can be taken while rst is asserted.
    always_comb begin
        imem_req  = !rst && (state_q == ST_REQ) && (!if_valid || if_ready) && !br_taken;
        imem_addr = pc_q;
    end

    assign rsp_fire = (state_q == ST_WAIT) && imem_rvalid;
    assign load     = rsp_fire && !drop_q && !br_taken;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        if (br_taken) begin
            pc_d = word_align(br_target);
            if (state_q == ST_WAIT) begin
                // The in-flight response is discarded now or marked to be discarded on arrival.
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                    drop_d  = 1'b0;
                end else begin
                    drop_d  = 1'b1;
                end
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem_req && imem_gnt) begin
                        req_pc_d = pc_q;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = ST_REQ;
                        drop_d  = 1'b0;
                        if (!drop_q) begin
                            pc_d = req_pc_q + 32'(WORD_BYTES);
                        end
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_REQ;
            pc_q     <= word_align(RESET_PC);
            req_pc_q <= '0;
            drop_q   <= 1'b0;
            br_mis_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            br_mis_q <= br_taken && (|br_target[1:0]);
        end
    end

    fetch_out_reg u_out_reg (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (load),
        .flush_i (br_taken),
        .ready_i (if_ready),
        .pc_i    (req_pc_q),
        .instr_i (imem_rdata),
        .valid_o (if_valid),
        .pc_o    (if_pc),
        .pc4_o   (if_pc4),
        .instr_o (if_instr)
    );

    assign if_imm16      = if_instr[IMM_MSB:IMM_LSB];
    assign br_misaligned = br_mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a transaction-level reference model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gnt = 1'b0, rvalid = 1'b0, if_ready = 1'b1, br_taken = 1'b0;
    logic [31:0] rdata = '0, br_target = '0;
    logic        imem_req, if_valid, br_misaligned;
    logic [31:0] imem_addr, if_pc, if_pc4, if_instr;
    logic [15:0] if_imm16;

    logic        gnt2 = 1'b0, rvalid2 = 1'b0;
    logic [31:0] rdata2 = '0;
    logic        req2, valid2, mis2;
    logic [31:0] addr2, pc2, pc42, instr2;
    logic [15:0] imm2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(gnt),
        .imem_rvalid(rvalid), .imem_rdata(rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_pc4(if_pc4),
        .if_instr(if_instr), .if_imm16(if_imm16),
        .br_taken(br_taken), .br_target(br_target), .br_misaligned(br_misaligned)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .if_valid(valid2), .if_ready(1'b1), .if_pc(pc2), .if_pc4(pc42),
        .if_instr(instr2), .if_imm16(imm2),
        .br_taken(1'b0), .br_target(32'h0), .br_misaligned(mis2)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: tracks next fetch address, one outstanding response and the held entry.
    bit          m_live = 0, m_pending = 0, m_kill = 0, m_valid = 0, m_mis = 0, m_req_now;
    logic [31:0] m_next, m_paddr, m_pc, m_instr;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_pending = 0; m_kill = 0; m_valid = 0; m_mis = 0;
            m_next = 32'h0; m_pc = 32'h0; m_instr = 32'h0;
        end else if (m_live) begin
            m_req_now = !m_pending && (!m_valid || if_ready) && !br_taken;
            m_mis = br_taken && (br_target[1:0] != 2'b00);
            if (br_taken) begin
                m_next  = br_target & 32'hFFFF_FFFC;
                m_valid = 0;
                if (m_pending) begin
                    if (rvalid) begin m_pending = 0; m_kill = 0; end
                    else m_kill = 1;
                end
            end else begin
                if (m_valid && if_ready) m_valid = 0;
                if (m_pending && rvalid) begin
                    m_pending = 0;
                    if (!m_kill) begin
                        m_valid = 1; m_pc = m_paddr; m_instr = rdata; m_next = m_paddr + 32'd4;
                    end
                    m_kill = 0;
                end else if (m_req_now && gnt) begin
                    m_pending = 1; m_paddr = m_next;
                end
            end
        end
    end

    always @(negedge clk) begin
        #3;
        if (m_live) begin
            chk("imem_req", imem_req, !rst && !m_pending && (!m_valid || if_ready) && !br_taken);
            if (imem_req) chk("imem_addr", imem_addr, m_next);
            chk("if_valid", if_valid, m_valid);
            chk("br_misaligned", br_misaligned, m_mis);
            if (m_valid) begin
                chk("if_pc", if_pc, m_pc);
                chk("if_pc4", if_pc4, m_pc + 32'd4);
                chk("if_instr", if_instr, m_instr);
                chk("if_imm16", if_imm16, m_instr[15:0]);
            end
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic wait_req(input logic [31:0] exp_addr, input string nm);
        int n;
        n = 0;
        #1;
        while (!imem_req && n < 40) begin tick(); #1; n++; end
        chk({nm, "_req_seen"}, imem_req, 1'b1);
        chk(nm, imem_addr, exp_addr);
    endtask

    task automatic do_fetch(input logic [31:0] data, input logic [31:0] exp_addr, input string nm);
        wait_req(exp_addr, nm);
        gnt = 1'b1; tick(); gnt = 1'b0;
        rvalid = 1'b1; rdata = data; tick(); rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick(); tick();
        #1;
        chk("rst_if_valid", if_valid, 1'b0);
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_br_mis", br_misaligned, 1'b0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        rst = 1'b0;

        // basic sequence 0x0, 0x4, 0x8
        do_fetch(32'h1000_0003, 32'h0, "addr_0");
        #1;
        chk("t1_valid", if_valid, 1'b1);
        chk("t1_pc", if_pc, 32'h0);
        chk("t1_pc4", if_pc4, 32'h4);
        chk("t1_imm16", if_imm16, 16'h0003);
        do_fetch(32'h1000_0003, 32'h4, "addr_4");
        do_fetch(32'h1000_0003, 32'h8, "addr_8");

        // backpressure
        do_fetch(32'hAABB_CCDD, 32'hC, "addr_c");
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_req", imem_req, 1'b0);
            chk("bp_pc", if_pc, 32'hC);
            chk("bp_instr", if_instr, 32'hAABB_CCDD);
            tick();
        end
        if_ready = 1'b1;
        do_fetch(32'h0000_0010, 32'h10, "bp_next");

        // redirect while waiting for the response
        wait_req(32'h14, "addr_14");
        gnt = 1'b1; tick(); gnt = 1'b0;
        br_taken = 1'b1; br_target = 32'h40; tick(); br_taken = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; tick(); rvalid = 1'b0;
        #1;
        chk("drop_valid", if_valid, 1'b0);
        do_fetch(32'h0000_0040, 32'h40, "redir_40");

        // redirect coincident with rvalid
        wait_req(32'h44, "addr_44");
        gnt = 1'b1; tick(); gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'h1111_1111; br_taken = 1'b1; br_target = 32'h80;
        tick();
        rvalid = 1'b0; br_taken = 1'b0;
        do_fetch(32'h2222_2222, 32'h80, "redir_80");
        #1;
        chk("coinc_valid", if_valid, 1'b1);
        chk("coinc_instr", if_instr, 32'h2222_2222);

        // misaligned redirect from REQ
        br_taken = 1'b1; br_target = 32'h0000_0102;
        #1;
        chk("br_forces_req_low", imem_req, 1'b0);
        tick(); br_taken = 1'b0;
        #1; chk("mis_pulse", br_misaligned, 1'b1);
        tick();
        #1; chk("mis_clear", br_misaligned, 1'b0);
        do_fetch(32'h0000_0100, 32'h100, "mis_100");

        // reset while waiting for the response
        wait_req(32'h104, "addr_104");
        gnt = 1'b1; tick(); gnt = 1'b0;
        rst = 1'b1; tick();
        #1;
        chk("wrst_valid", if_valid, 1'b0);
        chk("wrst_req", imem_req, 1'b0);
        chk("wrst_pc", if_pc, 32'h0);
        chk("wrst_instr", if_instr, 32'h0);
        rst = 1'b0;
        do_fetch(32'h3333_0000, 32'h0, "wrst_restart");
        #1;
        chk("wrst_out_pc", if_pc, 32'h0);

        // wrap-around with RESET_PC at the top of the address space
        n = 0;
        while (!req2 && n < 40) begin tick(); #1; n++; end
        chk("wrap_req", req2, 1'b1);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
        gnt2 = 1'b1; tick(); gnt2 = 1'b0;
        rvalid2 = 1'b1; rdata2 = 32'h1234_5678; tick(); rvalid2 = 1'b0;
        #1;
        chk("wrap_valid", valid2, 1'b1);
        chk("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc42, 32'h0);
        chk("wrap_imm16", imm2, 16'h5678);
        chk("wrap_req2", req2, 1'b1);
        chk("wrap_addr1", addr2, 32'h0);

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
